// File: rtl/load_return_unit_if.sv
// Load request / target read / load response bundle for load_return_unit.
// Latency: none (wiring only).
// Backpressure: none; the core side must hold i_ld_req until o_ld_busy is low at a clock edge.
//
// Port summary:
//   core -> unit : i_ld_req, i_ld_addr[31:0], i_ld_funct3[2:0]
//   unit -> core : o_ld_busy, o_ld_data[31:0], o_ld_valid, o_ld_err
//   unit -> tgt  : o_rd_addr[31:0], o_mem_rden, o_io_rden
//   tgt  -> unit : i_mem_rdata[31:0], i_io_rdata[31:0]
interface load_return_unit_if;
  logic        i_ld_req;
  logic [31:0] i_ld_addr;
  logic [2:0]  i_ld_funct3;
  logic        o_ld_busy;
  logic [31:0] o_rd_addr;
  logic        o_mem_rden;
  logic        o_io_rden;
  logic [31:0] i_mem_rdata;
  logic [31:0] i_io_rdata;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_ld_err;

  // The load unit itself.
  modport slave (
    input  i_ld_req, i_ld_addr, i_ld_funct3, i_mem_rdata, i_io_rdata,
    output o_ld_busy, o_rd_addr, o_mem_rden, o_io_rden, o_ld_data, o_ld_valid, o_ld_err
  );

  // Core plus read targets driving the load unit.
  modport master (
    output i_ld_req, i_ld_addr, i_ld_funct3, i_mem_rdata, i_io_rdata,
    input  o_ld_busy, o_rd_addr, o_mem_rden, o_io_rden, o_ld_data, o_ld_valid, o_ld_err
  );
endinterface

// File: rtl/load_return_unit.sv
// Load return unit: decodes a load to DMEM or IO, strobes one read, formats and returns the data.
// Latency: result valid LAT+2 cycles after the accepting edge's cycle; decode errors return 1 cycle later.
// Backpressure: o_ld_busy high from accept through RESP; requests seen while busy are dropped, not queued.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), asynchronous active-high reset
//   bus (slave modport)   i_ld_req/i_ld_addr/i_ld_funct3 request, o_ld_busy,
//                         o_rd_addr/o_mem_rden/o_io_rden read strobe to targets,
//                         i_mem_rdata/i_io_rdata read words,
//                         o_ld_data/o_ld_valid/o_ld_err response
module load_return_unit #(
  parameter int DMEM_BYTES = 2048,
  parameter int MEM_RD_LAT = 1,
  parameter int IO_RD_LAT  = 2
) (
  input logic               i_clk,
  input logic               i_reset,
  load_return_unit_if.slave bus
);

  localparam int MAX_LAT = (MEM_RD_LAT > IO_RD_LAT) ? MEM_RD_LAT : IO_RD_LAT;
  // Counter only ever holds LAT-1 down to 0.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MEM_CNT_INIT = CNT_W'(MEM_RD_LAT - 1);
  localparam logic [CNT_W-1:0] IO_CNT_INIT  = CNT_W'(IO_RD_LAT - 1);

  localparam logic [27:0] DMEM_LIMIT = 28'(DMEM_BYTES);
  localparam logic [27:0] IO_LAST    = 28'h001_0FFF;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q,   state_d;
  logic [31:0]       rd_addr_q, rd_addr_d;
  logic [1:0]        lane_q,    lane_d;
  logic [2:0]        funct3_q,  funct3_d;
  logic              tgt_io_q,  tgt_io_d;
  logic              err_q,     err_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [31:0]       ld_data_q, ld_data_d;

  logic              region_err;
  logic              align_err;
  logic              funct3_err;
  logic              dec_err;
  logic [31:0]       rdata_sel;

  // Extract the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Decode straight off the request so an error can skip ISSUE/WAIT and respond next cycle.
  always_comb begin
    region_err = 1'b1;
    if (bus.i_ld_addr[31:28] == 4'h0) begin
      region_err = (bus.i_ld_addr[27:0] >= DMEM_LIMIT);
    end else if (bus.i_ld_addr[31:28] == 4'h1) begin
      region_err = (bus.i_ld_addr[27:0] > IO_LAST);
    end

    align_err  = 1'b0;
    funct3_err = 1'b0;
    case (bus.i_ld_funct3)
      F3_LB, F3_LBU: align_err = 1'b0;
      F3_LH, F3_LHU: align_err = bus.i_ld_addr[0];
      F3_LW:         align_err = |bus.i_ld_addr[1:0];
      default:       funct3_err = 1'b1;
    endcase

    dec_err = region_err | align_err | funct3_err;
  end

  // Only the selected target's word is looked at, and only in the sample cycle.
  assign rdata_sel = tgt_io_q ? bus.i_io_rdata : bus.i_mem_rdata;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    lane_d    = lane_q;
    funct3_d  = funct3_q;
    tgt_io_d  = tgt_io_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    ld_data_d = ld_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_ld_req) begin
          rd_addr_d = {bus.i_ld_addr[31:2], 2'b00};
          lane_d    = bus.i_ld_addr[1:0];
          funct3_d  = bus.i_ld_funct3;
          tgt_io_d  = (bus.i_ld_addr[31:28] == 4'h1);
          if (dec_err) begin
            err_d     = 1'b1;
            ld_data_d = 32'd0;
            state_d   = ST_RESP;
          end else begin
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = tgt_io_q ? IO_CNT_INIT : MEM_CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          ld_data_d = format_load(rdata_sel, lane_q, funct3_q);
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // RESP: single-cycle response; the error flag does not outlive it.
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= 32'd0;
      lane_q    <= 2'd0;
      funct3_q  <= 3'd0;
      tgt_io_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      ld_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      lane_q    <= lane_d;
      funct3_q  <= funct3_d;
      tgt_io_q  <= tgt_io_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign bus.o_ld_busy  = (state_q != ST_IDLE);
  assign bus.o_rd_addr  = rd_addr_q;
  assign bus.o_mem_rden = (state_q == ST_ISSUE) && !tgt_io_q;
  assign bus.o_io_rden  = (state_q == ST_ISSUE) &&  tgt_io_q;
  assign bus.o_ld_data  = ld_data_q;
  assign bus.o_ld_valid = (state_q == ST_RESP);
  assign bus.o_ld_err   = err_q;

endmodule

// File: tb/tb_load_return_unit.sv
module tb_load_return_unit;
  localparam int MEM_LAT    = 1;
  localparam int IO_LAT     = 2;
  localparam int DMEM_BYTES = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;

  load_return_unit_if bus();

  load_return_unit #(
    .DMEM_BYTES(DMEM_BYTES),
    .MEM_RD_LAT(MEM_LAT),
    .IO_RD_LAT (IO_LAT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Target models: DMEM contents and the IO register value.
  logic [31:0] dmem [512];
  logic [31:0] io_word;
  logic [31:0] mem_word;
  int mem_rden_cnt = 0, io_rden_cnt = 0;
  int mem_rden_cyc = -1, io_rden_cyc = -1;
  int mem_due = -1, io_due = -1;

  // Read data is correct only in the cycle LAT after the strobe; garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (bus.o_mem_rden) begin
      mem_rden_cnt++;
      mem_rden_cyc = cyc;
      mem_due      = cyc + MEM_LAT;
      mem_word     = dmem[bus.o_rd_addr[10:2]];
    end
    if (bus.o_io_rden) begin
      io_rden_cnt++;
      io_rden_cyc = cyc;
      io_due      = cyc + IO_LAT;
    end
    bus.i_mem_rdata = (cyc == mem_due) ? mem_word : $urandom();
    bus.i_io_rdata  = (cyc == io_due)  ? io_word  : $urandom();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: region/alignment/type rules and extension done with plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [2:0] f3,
                                output bit err, output logic [31:0] d,
                                output int lat, output bit is_io);
    int unsigned region, off, size;
    logic [31:0] word, v;
    bit sgn;
    region = a >> 28;
    off    = a & 32'h0FFF_FFFF;
    is_io  = (region == 1);
    err    = !((region == 0 && off < DMEM_BYTES) || (region == 1 && off <= 32'h0001_0FFF));
    size = 4;
    sgn  = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: err = 1;
    endcase
    if (a % size != 0) err = 1;
    d   = 32'd0;
    lat = 1;
    if (!err) begin
      word = is_io ? io_word : dmem[off / 4];
      v    = word >> (8 * (a % 4));
      if (size == 1) begin
        v = v % 256;
        if (sgn && v >= 128) v = v - 256;
      end else if (size == 2) begin
        v = v % 65536;
        if (sgn && v >= 32768) v = v - 65536;
      end
      d   = v;
      lat = 2 + (is_io ? IO_LAT : MEM_LAT);
    end
  endfunction

  // One complete load; called at #2 after a rising edge.
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input string tag,
                          input bit has_gold, input logic [31:0] gold);
    bit e, is_io, seen;
    logic [31:0] d;
    int lat, c0, m0, i0, g;
    g = 0;
    while (bus.o_ld_busy && g < 40) begin
      @(posedge clk); #2;
      g++;
    end
    chk({tag, ":idle_before"}, 32'(bus.o_ld_busy), 32'd0);
    model(a, f3, e, d, lat, is_io);
    bus.i_ld_req    = 1'b1;
    bus.i_ld_addr   = a;
    bus.i_ld_funct3 = f3;
    c0 = cyc;
    m0 = mem_rden_cnt;
    i0 = io_rden_cnt;
    @(posedge clk); #2;
    bus.i_ld_req    = 1'b0;
    bus.i_ld_addr   = $urandom();
    bus.i_ld_funct3 = 3'($urandom());
    chk({tag, ":busy"}, 32'(bus.o_ld_busy), 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.o_ld_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #2;
    end
    chk({tag, ":valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, ":latency"}, 32'(cyc - c0), 32'(lat));
      chk({tag, ":err"}, 32'(bus.o_ld_err), 32'(e));
      chk({tag, ":data"}, bus.o_ld_data, d);
      if (has_gold) chk({tag, ":gold"}, bus.o_ld_data, gold);
      if (!e) chk({tag, ":rd_addr"}, bus.o_rd_addr, {a[31:2], 2'b00});
    end
    chk({tag, ":mem_rden_cnt"}, 32'(mem_rden_cnt - m0), 32'((!e && !is_io) ? 1 : 0));
    chk({tag, ":io_rden_cnt"}, 32'(io_rden_cnt - i0), 32'((!e && is_io) ? 1 : 0));
    if (!e && !is_io) chk({tag, ":mem_rden_cyc"}, 32'(mem_rden_cyc - c0), 32'd1);
    if (!e && is_io) chk({tag, ":io_rden_cyc"}, 32'(io_rden_cyc - c0), 32'd1);
    @(posedge clk); #2;
    chk({tag, ":valid_pulse"}, 32'(bus.o_ld_valid), 32'd0);
    chk({tag, ":err_clear"}, 32'(bus.o_ld_err), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ":busy"}, 32'(bus.o_ld_busy), 32'd0);
    chk({tag, ":valid"}, 32'(bus.o_ld_valid), 32'd0);
    chk({tag, ":err"}, 32'(bus.o_ld_err), 32'd0);
    chk({tag, ":mem_rden"}, 32'(bus.o_mem_rden), 32'd0);
    chk({tag, ":io_rden"}, 32'(bus.o_io_rden), 32'd0);
    chk({tag, ":data"}, bus.o_ld_data, 32'd0);
    chk({tag, ":rd_addr"}, bus.o_rd_addr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_pool [13];
    logic [31:0] a, exp_d;
    int c0, m0, nvalid, period, kind;
    int vk[$];
    logic [31:0] vd[$];
    int ek[$];
    logic [31:0] ed[$];

    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 512; i++) dmem[i] = $urandom();
    dmem[32'h104 >> 2] = 32'h8070_F0FF;
    io_word = 32'h0;
    bus.i_ld_req    = 1'b0;
    bus.i_ld_addr   = 32'h0;
    bus.i_ld_funct3 = 3'd0;
    bus.i_mem_rdata = 32'h0;
    bus.i_io_rdata  = 32'h0;

    #3;
    chk_outputs_zero("reset");
    #9 rst = 1'b0;
    @(posedge clk); #2;

    // Directed loads from the reference word.
    run_load(32'h0000_0104, 3'd0, "lb_104",  1, 32'hFFFF_FFFF);
    run_load(32'h0000_0107, 3'd4, "lbu_107", 1, 32'h0000_0080);
    run_load(32'h0000_0106, 3'd5, "lhu_106", 1, 32'h0000_8070);
    run_load(32'h0000_0106, 3'd1, "lh_106",  1, 32'hFFFF_8070);
    run_load(32'h0000_0104, 3'd2, "lw_104",  1, 32'h8070_F0FF);
    io_word = 32'h0000_03A5;
    run_load(32'h1001_0000, 3'd2, "lw_io",   1, 32'h0000_03A5);
    run_load(32'h0000_0802, 3'd2, "lw_misal",   1, 32'h0);
    run_load(32'h0000_0800, 3'd2, "lw_unmap",   1, 32'h0);
    run_load(32'h2000_0000, 3'd2, "lw_region",  1, 32'h0);
    run_load(32'h0000_0104, 3'd3, "funct3_bad", 1, 32'h0);
    run_load(32'h0000_07FC, 3'd2, "lw_dmem_top", 0, 32'h0);
    run_load(32'h1001_0FFC, 3'd2, "lw_io_top",   0, 32'h0);
    run_load(32'h1001_1000, 3'd2, "lw_io_past",  1, 32'h0);

    // Randomized loads checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5)      a = 32'($urandom_range(0, DMEM_BYTES - 1));
      else if (kind <= 7) a = 32'h1000_0000 + 32'($urandom_range(0, 32'h10FFF));
      else if (kind == 8) a = $urandom();
      else                a = 32'h7F8 + 32'($urandom_range(0, 16));
      io_word = $urandom();
      run_load(a, f3_pool[$urandom_range(0, 12)], $sformatf("rand%0d", n), 0, 32'h0);
    end

    // Request held every cycle with a fresh address: only requests seen while idle are taken.
    period = 3 + MEM_LAT;
    for (int j = 0; j < 10; j += period) begin
      ek.push_back(j + 2 + MEM_LAT);
      ed.push_back(dmem[(32'h100 + 4 * j) >> 2]);
    end
    c0 = cyc;
    m0 = mem_rden_cnt;
    for (int k = 0; k < 16; k++) begin
      if (k < 10) begin
        bus.i_ld_req    = 1'b1;
        bus.i_ld_addr   = 32'h100 + 32'(4 * k);
        bus.i_ld_funct3 = 3'd2;
      end else begin
        bus.i_ld_req = 1'b0;
      end
      if (bus.o_ld_valid) begin
        vk.push_back(cyc - c0);
        vd.push_back(bus.o_ld_data);
      end
      @(posedge clk); #2;
    end
    chk("b2b:valid_count", 32'(vk.size()), 32'(ek.size()));
    chk("b2b:mem_rden_count", 32'(mem_rden_cnt - m0), 32'(ek.size()));
    for (int i = 0; i < ek.size() && i < vk.size(); i++) begin
      chk($sformatf("b2b:valid_cyc%0d", i), 32'(vk[i]), 32'(ek[i]));
      chk($sformatf("b2b:data%0d", i), vd[i], ed[i]);
    end

    // Reset pulse in the middle of a load.
    bus.i_ld_req    = 1'b1;
    bus.i_ld_addr   = 32'h0000_0104;
    bus.i_ld_funct3 = 3'd2;
    @(posedge clk); #2;
    bus.i_ld_req = 1'b0;
    @(posedge clk); #2;
    chk("rst_mid:busy_before", 32'(bus.o_ld_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("rst_mid");
    @(posedge clk); #2;
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.o_ld_valid) nvalid++;
      @(posedge clk); #2;
    end
    chk("rst_mid:no_valid", 32'(nvalid), 32'd0);
    chk("rst_mid:idle", 32'(bus.o_ld_busy), 32'd0);
    exp_d = 32'h8070_F0FF;
    run_load(32'h0000_0104, 3'd2, "lw_after_rst", 1, exp_d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
